// File: rtl/divider_arb_pkg.sv
// Shared types for the two-requester divider arbiter: one-hot FSM states
// and the owner encoding used by the arbiter and its round-robin picker.
package divider_arb_pkg;

    typedef enum logic [4:0] {
        IDLE  = 5'b00001,
        ISSUE = 5'b00010,
        WAIT  = 5'b00100,
        RESP  = 5'b01000,
        ZERR  = 5'b10000
    } arb_state_t;

    localparam logic OWN_A = 1'b0;
    localparam logic OWN_B = 1'b1;

endpackage

// File: rtl/divider_arbiter_rr_arb2.sv
// Two-way round-robin picker; the pointer names the side that wins a tie
// and flips to the loser's side whenever a grant is taken.
module rr_arb2
    import divider_arb_pkg::*;
(
    input  logic Clk,
    input  logic Reset,
    input  logic req_a,
    input  logic req_b,
    input  logic advance,
    output logic valid,
    output logic pick
);

    logic ptr_r;

    // Combinational pick: a lone requester wins, a tie goes to the pointer.
    always_comb begin
        valid = req_a | req_b;
        if (req_a && req_b) begin
            pick = ptr_r;
        end else if (req_a) begin
            pick = OWN_A;
        end else begin
            pick = OWN_B;
        end
    end

    // Pointer register, moved past the winner on every accepted grant.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ptr_r <= OWN_A;
        end else if (advance) begin
            ptr_r <= ~pick;
        end
    end

endmodule

// File: rtl/divider_arbiter.sv
// Shares one iterative divider between requesters A and B: round-robin
// grant, handshake sequencing, divide-by-zero screening and a hang watchdog.
module divider_arbiter
    import divider_arb_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             ReqA,
    input  logic [WIDTH-1:0] XA,
    input  logic [WIDTH-1:0] YA,
    input  logic             ReqB,
    input  logic [WIDTH-1:0] XB,
    input  logic [WIDTH-1:0] YB,
    output logic             GntA,
    output logic             GntB,
    output logic             DoneA,
    output logic             DoneB,
    output logic [WIDTH-1:0] Quo,
    output logic [WIDTH-1:0] Rem,
    output logic             Err,
    output logic [WIDTH-1:0] Div_Xin,
    output logic [WIDTH-1:0] Div_Yin,
    output logic             Div_Start,
    output logic             Div_Ack,
    output logic             Div_Reset,
    input  logic             Div_Done,
    input  logic [WIDTH-1:0] Div_Quotient,
    input  logic [WIDTH-1:0] Div_Remainder
);

    localparam int CW = $clog2(TIMEOUT + 1);

    arb_state_t       state_r, state_s;
    logic             owner_r, owner_s;
    logic [CW-1:0]    cnt_r;
    logic             valid_s, pick_s, take_s;
    logic             done_s, timeout_s;
    logic [WIDTH-1:0] win_x_s, win_y_s;

    rr_arb2 u_rr (
        .Clk     (Clk),
        .Reset   (Reset),
        .req_a   (ReqA),
        .req_b   (ReqB),
        .advance (take_s),
        .valid   (valid_s),
        .pick    (pick_s)
    );

    // Winner selection and the two ways out of WAIT.
    always_comb begin
        take_s    = (state_r == IDLE) && valid_s;
        owner_s   = take_s ? pick_s : owner_r;
        win_x_s   = (pick_s == OWN_B) ? XB : XA;
        win_y_s   = (pick_s == OWN_B) ? YB : YA;
        done_s    = (state_r == WAIT) && Div_Done;
        timeout_s = (state_r == WAIT) && !Div_Done && (cnt_r == CW'(TIMEOUT - 1));
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (take_s) begin
                    state_s = (win_y_s == {WIDTH{1'b0}}) ? ZERR : ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: state_s = WAIT;
            WAIT: begin
                if (done_s || timeout_s) begin
                    state_s = RESP;
                end else begin
                    state_s = WAIT;
                end
            end
            RESP:    state_s = IDLE;
            ZERR:    state_s = RESP;
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Handshake pulses are decoded from the next state so they line up with it.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            GntA      <= 1'b0;
            GntB      <= 1'b0;
            DoneA     <= 1'b0;
            DoneB     <= 1'b0;
            Div_Start <= 1'b0;
            Div_Ack   <= 1'b0;
            Div_Reset <= 1'b1;
        end else begin
            GntA      <= (state_s == ISSUE || state_s == ZERR) && (owner_s == OWN_A);
            GntB      <= (state_s == ISSUE || state_s == ZERR) && (owner_s == OWN_B);
            DoneA     <= (state_s == RESP) && (owner_r == OWN_A);
            DoneB     <= (state_s == RESP) && (owner_r == OWN_B);
            Div_Start <= (state_s == ISSUE);
            Div_Ack   <= done_s;
            Div_Reset <= timeout_s;
        end
    end

    // Operand capture, watchdog counter and result registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            owner_r <= OWN_A;
            Div_Xin <= {WIDTH{1'b0}};
            Div_Yin <= {WIDTH{1'b0}};
            cnt_r   <= {CW{1'b0}};
            Quo     <= {WIDTH{1'b0}};
            Rem     <= {WIDTH{1'b0}};
            Err     <= 1'b0;
        end else begin
            if (take_s) begin
                owner_r <= pick_s;
                Div_Xin <= win_x_s;
                Div_Yin <= win_y_s;
            end
            if (state_r == ISSUE) begin
                cnt_r <= {CW{1'b0}};
            end else if (state_r == WAIT && cnt_r != CW'(TIMEOUT)) begin
                cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
            end
            if (done_s) begin
                Quo <= Div_Quotient;
                Rem <= Div_Remainder;
                Err <= 1'b0;
            end else if (timeout_s) begin
                Quo <= {WIDTH{1'b0}};
                Rem <= {WIDTH{1'b0}};
                Err <= 1'b1;
            end else if (state_r == ZERR) begin
                Quo <= {WIDTH{1'b0}};
                Rem <= Div_Xin;
                Err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_divider_arbiter.sv
// Self-checking bench: behavioural divider stub plus a reference model of
// arbitration order, results and handshake timing.
module tb_divider_arbiter;

    localparam int WIDTH   = 4;
    localparam int TIMEOUT = 15;

    logic             Clk = 1'b0;
    logic             Reset;
    logic             ReqA, ReqB;
    logic [WIDTH-1:0] XA, YA, XB, YB;
    logic             GntA, GntB, DoneA, DoneB, Err;
    logic [WIDTH-1:0] Quo, Rem, Div_Xin, Div_Yin;
    logic             Div_Start, Div_Ack, Div_Reset;
    logic             Div_Done;
    logic [WIDTH-1:0] Div_Quotient, Div_Remainder;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_start = 0, n_ack = 0, n_rst = 0;
    int rise_cyc = 0;
    bit hang = 1'b0;
    bit ptr  = 1'b0;

    logic             busy;
    int               lat;
    logic [WIDTH-1:0] sq, sr;

    divider_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .Clk(Clk), .Reset(Reset),
        .ReqA(ReqA), .XA(XA), .YA(YA),
        .ReqB(ReqB), .XB(XB), .YB(YB),
        .GntA(GntA), .GntB(GntB), .DoneA(DoneA), .DoneB(DoneB),
        .Quo(Quo), .Rem(Rem), .Err(Err),
        .Div_Xin(Div_Xin), .Div_Yin(Div_Yin),
        .Div_Start(Div_Start), .Div_Ack(Div_Ack), .Div_Reset(Div_Reset),
        .Div_Done(Div_Done), .Div_Quotient(Div_Quotient), .Div_Remainder(Div_Remainder)
    );

    always #5 Clk = ~Clk;

    // Divider stub with random latency; optionally hangs. Also counts pulses.
    always @(posedge Clk) begin
        cyc <= cyc + 1;
        if (Div_Start) n_start <= n_start + 1;
        if (Div_Ack)   n_ack   <= n_ack + 1;
        if (Div_Reset) n_rst   <= n_rst + 1;
        if (Reset || Div_Reset) begin
            busy <= 1'b0; Div_Done <= 1'b0; lat <= 0;
            Div_Quotient <= '0; Div_Remainder <= '0;
        end else if (Div_Start) begin
            busy <= !hang;
            lat  <= $urandom_range(0, 3);
            sq   <= (Div_Yin != 0) ? Div_Xin / Div_Yin : '0;
            sr   <= (Div_Yin != 0) ? Div_Xin % Div_Yin : '0;
        end else if (busy) begin
            if (lat == 0) begin
                Div_Done <= 1'b1; Div_Quotient <= sq; Div_Remainder <= sr;
                busy <= 1'b0; rise_cyc <= cyc;
            end else begin
                lat <= lat - 1;
            end
        end else if (Div_Ack) begin
            Div_Done <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Waits for the owner's Done and checks result, timing and divider pulses.
    task automatic check_result(input bit own, input logic [3:0] x, input logic [3:0] y,
                                input int gnt_cyc, input int s0, input int a0, input int r0);
        bit seen = 1'b0;
        logic [3:0] eq, er;
        logic ee;
        int exp_cyc;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            if (DoneA || DoneB) begin seen = 1'b1; break; end
        end
        chk("done_seen", 32'(seen), 32'd1);
        if (!seen) return;
        if (y == 0)      begin eq = 4'd0;  er = x;     ee = 1'b1; exp_cyc = gnt_cyc + 1; end
        else if (hang)   begin eq = 4'd0;  er = 4'd0;  ee = 1'b1; exp_cyc = gnt_cyc + TIMEOUT + 1; end
        else             begin eq = x / y; er = x % y; ee = 1'b0; exp_cyc = rise_cyc + 2; end
        chk("done_owner", {30'd0, DoneB, DoneA}, own ? 32'd2 : 32'd1);
        chk("quo", 32'(Quo), 32'(eq));
        chk("rem", 32'(Rem), 32'(er));
        chk("err", 32'(Err), 32'(ee));
        chk("done_time", 32'(cyc), 32'(exp_cyc));
        @(negedge Clk);
        chk("done_pulse", {30'd0, DoneB, DoneA}, 32'd0);
        chk("n_start", 32'(n_start - s0), (y != 0) ? 32'd1 : 32'd0);
        chk("n_ack", 32'(n_ack - a0), (y != 0 && !hang) ? 32'd1 : 32'd0);
        chk("n_rst", 32'(n_rst - r0), (y != 0 && hang) ? 32'd1 : 32'd0);
    endtask

    // Raises the chosen requests and serves them in model order.
    task automatic serve(input bit ra, input bit rb, input logic [3:0] xa, input logic [3:0] ya,
                         input logic [3:0] xb, input logic [3:0] yb);
        bit pa = ra, pb = rb, w, got;
        int g, s0, a0, r0;
        @(negedge Clk);
        ReqA = ra; XA = xa; YA = ya;
        ReqB = rb; XB = xb; YB = yb;
        while (pa || pb) begin
            got = 1'b0;
            for (int i = 1; i <= 20; i++) begin
                @(negedge Clk);
                if (GntA || GntB) begin got = 1'b1; chk("gnt_latency", 32'(i), 32'd1); break; end
            end
            chk("gnt_seen", 32'(got), 32'd1);
            if (!got) break;
            w = (pa && pb) ? ptr : (pa ? 1'b0 : 1'b1);
            chk("gnt_owner", {30'd0, GntB, GntA}, w ? 32'd2 : 32'd1);
            g = cyc; s0 = n_start; a0 = n_ack; r0 = n_rst;
            if (w) begin ReqB = 1'b0; pb = 1'b0; end
            else   begin ReqA = 1'b0; pa = 1'b0; end
            ptr = ~w;
            check_result(w, w ? xb : xa, w ? yb : ya, g, s0, a0, r0);
        end
    endtask

    initial begin
        int quiet;
        int r;
        Reset = 1'b1; ReqA = 1'b0; ReqB = 1'b0;
        XA = '0; YA = '0; XB = '0; YB = '0;
        @(negedge Clk);
        chk("rst_div_reset", 32'(Div_Reset), 32'd1);
        chk("rst_outputs", {26'd0, GntA, GntB, DoneA, DoneB, Div_Start, Div_Ack}, 32'd0);
        chk("rst_quo_rem_err", {23'd0, Quo, Rem, Err}, 32'd0);
        chk("rst_xin_yin", {24'd0, Div_Xin, Div_Yin}, 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        chk("div_reset_clear", 32'(Div_Reset), 32'd0);

        serve(1'b1, 1'b0, 4'd13, 4'd3, 4'd0, 4'd0);
        serve(1'b1, 1'b1, 4'd15, 4'd2, 4'd9, 4'd4);
        serve(1'b1, 1'b1, 4'd15, 4'd2, 4'd9, 4'd4);
        serve(1'b0, 1'b1, 4'd0, 4'd0, 4'd7, 4'd0);
        serve(1'b1, 1'b0, 4'd2, 4'd5, 4'd0, 4'd0);
        serve(1'b1, 1'b0, 4'd3, 4'd3, 4'd0, 4'd0);

        hang = 1'b1;
        serve(1'b1, 1'b0, 4'd11, 4'd2, 4'd0, 4'd0);

        // Reset while the divider is hung in WAIT.
        @(negedge Clk);
        ReqA = 1'b1; XA = 4'd9; YA = 4'd2;
        @(negedge Clk);
        chk("rw_gnt", 32'(GntA), 32'd1);
        ReqA = 1'b0;
        repeat (4) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        chk("rw_div_reset", 32'(Div_Reset), 32'd1);
        Reset = 1'b0; hang = 1'b0; ptr = 1'b0;
        quiet = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            if (DoneA || DoneB) quiet++;
        end
        chk("rw_no_done", 32'(quiet), 32'd0);
        serve(1'b1, 1'b0, 4'd6, 4'd6, 4'd0, 4'd0);

        for (int k = 0; k < 24; k++) begin
            r = $urandom_range(1, 3);
            serve(r[0], r[1], 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/divider_arbiter.md
Name: divider_arbiter

Overview:
- Shares one iterative divider (WIDTH-bit operands; Start / Done / Ack handshake; Done held until Ack) between two requesters, A and B.
- Arbitrates round-robin and captures the winner's operands.
- Sequences the divider handshake, returns the quotient and remainder to the owner, and screens divide-by-zero.
- Recovers a hung divider through a watchdog timeout.
- Sits between client FSMs and the divider datapath.

Parameters:
- WIDTH, 4, operand, quotient and remainder width.
- TIMEOUT, 15, maximum cycles spent in WAIT before the operation is abandoned.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- ReqA  in  1  requester A has an operation pending (level).
- XA  in  WIDTH  requester A dividend.
- YA  in  WIDTH  requester A divisor.
- ReqB  in  1  requester B has an operation pending (level).
- XB  in  WIDTH  requester B dividend.
- YB  in  WIDTH  requester B divisor.
- GntA  out  1  one-cycle pulse: A's operands captured.
- GntB  out  1  one-cycle pulse: B's operands captured.
- DoneA  out  1  one-cycle pulse: result for A on Quo/Rem/Err.
- DoneB  out  1  one-cycle pulse: result for B on Quo/Rem/Err.
- Quo  out  WIDTH  quotient (registered).
- Rem  out  WIDTH  remainder (registered).
- Err  out  1  qualified by DoneA/DoneB: divide-by-zero or timeout.
- Div_Xin  out  WIDTH  registered dividend to divider.
- Div_Yin  out  WIDTH  registered divisor to divider.
- Div_Start  out  1  divider start.
- Div_Ack  out  1  divider acknowledge.
- Div_Reset  out  1  divider reset (registered).
- Div_Done  in  1  divider done.
- Div_Quotient  in  WIDTH  divider quotient.
- Div_Remainder  in  WIDTH  divider remainder.

Clock and reset: one clock, Clk. Reset is synchronous and active-high.

Behaviour:
- Reset values: state=IDLE, priority pointer=A, counter=0, all Gnt/Done/Err/Div_Start/Div_Ack=0, Quo=Rem=0, Div_Xin=Div_Yin=0.
- Div_Reset is 1 during the cycle after Reset is sampled high, then 0. This resets the divider together with the arbiter.
- Reset mid-operation: the arbiter returns to IDLE next cycle. No Done pulse is issued for the aborted operation.
- Arbitration (IDLE only):
  - Only one requester asserted: it wins.
  - Both asserted: the pointer side wins. After each grant the pointer moves to the other side.
  - Requests during non-IDLE states are not sampled.
- States (one-hot):
  - IDLE: on a winning request, register owner, X and Y, and move the pointer. If Y==0, go ZERR; otherwise go ISSUE.
  - ISSUE: Gnt(owner)=1, Div_Start=1, Div_Xin/Div_Yin hold captured operands. Counter=0. Go WAIT.
  - WAIT:
    - If Div_Done: latch Div_Quotient into Quo and Div_Remainder into Rem, Err=0, go RESP.
    - Else if counter==TIMEOUT-1: Quo=Rem=0, Err=1, pulse Div_Reset next cycle, go RESP.
    - Else increment counter.
  - RESP: Done(owner)=1 and Div_Ack=1 for one cycle. Div_Ack is suppressed on the timeout path. Go IDLE.
  - ZERR: Gnt(owner)=1, Quo=0, Rem=X, Err=1. Go RESP with Div_Ack suppressed. Div_Start is never asserted for Y==0.
- Latency:
  - Request sampled at edge T gives Gnt in cycle T+1.
  - Done appears 2 cycles after Div_Done is first seen high.
  - The divider's Done is cleared by Ack at the end of RESP. The next ISSUE is at least 2 cycles later, so the divider is back in its initial state by then.
- Requester rule: drop Req, or present a new operation, in the cycle after Gnt. A Req still high in IDLE is a new request.
- The counter is $clog2(TIMEOUT+1) bits wide and saturates; it never wraps.
- Quo and Rem hold their last values between Done pulses.

Decomposition:
- Package divider_arb_pkg:
  - state encoding localparams IDLE, ISSUE, WAIT, RESP, ZERR (one-hot);
  - owner encoding OWN_A=0, OWN_B=1.
- Sub-module rr_arb2: 2-way round-robin pick with pointer register.
- The FSM, counter and result registers stay in the top module.

Test Plan:
1. After reset, ReqA with XA=13, YA=3 → GntA at T+1; DoneA with Quo=4, Rem=1, Err=0. Div_Start and Div_Ack each pulse exactly once.
2. ReqA (XA=15, YA=2) and ReqB (XB=9, YB=4) asserted together, held → A served first (Quo=7, Rem=1), then B (Quo=2, Rem=1). The next simultaneous pair is served A-then-B again, since the pointer alternates.
3. ReqB with XB=7, YB=0 → GntB, then DoneB with Err=1, Quo=0, Rem=7. Div_Start, Div_Ack and Div_Reset stay 0 throughout.
4. Divider stub that never asserts Div_Done, with TIMEOUT=15 → Done(owner) with Err=1 exactly 15 WAIT cycles later. Div_Reset pulses for one cycle and Div_Ack stays 0.
5. Reset asserted during WAIT → IDLE next cycle, no Done pulse, Div_Reset pulse. A new ReqA (XA=6, YA=6) afterwards completes with Quo=1, Rem=0.
6. XA=2, YA=5 (X<Y) → Quo=0, Rem=2, Err=0. Also check the 3/3 edge case: Quo=1, Rem=0.
